// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
//   Ping-pong controller for two RGB line buffers. The write side fills one
//   bank from a valid/ready pixel stream. The read side streams the other,
//   full bank out on request. The banks' registered read data is muxed back
//   into a single output stream.
//
// Ports
//   Clock, Reset          single clock, synchronous active-high reset
//   PixIn/PixValid/PixReady   write-side pixel stream (valid/ready)
//   RdStart               one-cycle request to stream one line out
//   RdBusy                read sequence in progress
//   Underrun              one-cycle pulse: RdStart while no full bank is ready
//   PixOut/PixOutValid    read-side pixel stream
//   Addr0/1, WE0/1, RE0/1, BufferIn0/1   per-bank control and write data
//   Buf0OutR/G/B, Buf1OutR/G/B           registered bank read data
//   UnderrunCnt           saturating underrun counter (LBC_UNDERRUN_CNT_EN only)
//
// Build option
//   LBC_UNDERRUN_CNT_EN   adds the UnderrunCnt[15:0] output and its counter.
module line_buffer_ctrl #(
  parameter int LINE_LEN = 80,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 24
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] PixIn,
  input  logic              PixValid,
  output logic              PixReady,
  input  logic              RdStart,
  output logic              RdBusy,
  output logic              Underrun,
  output logic [DATA_W-1:0] PixOut,
  output logic              PixOutValid,
  output logic [ADDR_W-1:0] Addr0,
  output logic [ADDR_W-1:0] Addr1,
  output logic              WE0,
  output logic              WE1,
  output logic              RE0,
  output logic              RE1,
  output logic [DATA_W-1:0] BufferIn0,
  output logic [DATA_W-1:0] BufferIn1,
  input  logic [7:0]        Buf0OutR,
  input  logic [7:0]        Buf0OutG,
  input  logic [7:0]        Buf0OutB,
  input  logic [7:0]        Buf1OutR,
  input  logic [7:0]        Buf1OutG,
  input  logic [7:0]        Buf1OutB
`ifdef LBC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       UnderrunCnt
`endif
);

  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_LEN - 1);

  rd_state_t         rd_state, rd_state_nxt;
  logic              wr_bank, rd_bank, bank_pipe, valid_pipe, underrun_q;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [1:0]        full, full_nxt;

  logic wr_fire, wr_last, rd_active, rd_last, start_ok, underrun_nxt;

  assign PixReady  = !full[wr_bank];
  assign wr_fire   = PixValid && PixReady;
  assign wr_last   = wr_fire && (wr_addr == LAST);
  assign rd_active = (rd_state == RD_ACTIVE);
  assign rd_last   = rd_active && (rd_addr == LAST);
  assign start_ok     = !rd_active && RdStart && full[rd_bank];
  assign underrun_nxt = !rd_active && RdStart && !full[rd_bank];

  assign RdBusy      = rd_active;
  assign Underrun    = underrun_q;
  assign PixOutValid = valid_pipe;
  assign BufferIn0   = PixIn;
  assign BufferIn1   = PixIn;

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE:   if (start_ok) rd_state_nxt = RD_ACTIVE;
      RD_ACTIVE: if (rd_last)  rd_state_nxt = RD_IDLE;
      default:   rd_state_nxt = RD_IDLE;
    endcase
  end

  // The written bank is never full and the read bank is always full, so a
  // bank never sees a write and a read in the same cycle.
  always_comb begin
    Addr0 = '0;
    Addr1 = '0;
    WE0   = 1'b0;
    WE1   = 1'b0;
    RE0   = 1'b0;
    RE1   = 1'b0;
    if (wr_fire) begin
      if (wr_bank) begin WE1 = 1'b1; Addr1 = wr_addr; end
      else         begin WE0 = 1'b1; Addr0 = wr_addr; end
    end
    if (rd_active) begin
      if (rd_bank) begin RE1 = 1'b1; Addr1 = rd_addr; end
      else         begin RE0 = 1'b1; Addr0 = rd_addr; end
    end
  end

  // A final write and a final read in the same cycle hit different banks,
  // so the set and the clear both apply.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  always_comb begin
    PixOut = '0;
    if (bank_pipe) PixOut = {Buf1OutR, Buf1OutG, Buf1OutB};
    else           PixOut = {Buf0OutR, Buf0OutG, Buf0OutB};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_state   <= RD_IDLE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      full       <= '0;
      valid_pipe <= 1'b0;
      bank_pipe  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rd_state   <= rd_state_nxt;
      full       <= full_nxt;
      underrun_q <= underrun_nxt;
      valid_pipe <= rd_active;
      bank_pipe  <= rd_bank;
      if (wr_fire) begin
        if (wr_last) begin
          wr_addr <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (start_ok) begin
        rd_addr <= '0;
      end else if (rd_active) begin
        if (rd_last) begin
          rd_addr <= '0;
          rd_bank <= !rd_bank;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

`ifdef LBC_UNDERRUN_CNT_EN
  always_ff @(posedge Clock) begin
    if (Reset)                                 UnderrunCnt <= '0;
    else if (underrun_nxt && UnderrunCnt != '1) UnderrunCnt <= UnderrunCnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Testbench for line_buffer_ctrl: models the two registered line buffers,
// keeps a scoreboard of accepted pixels and checks the streamed output order.
module tb_line_buffer_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [23:0] PixIn = '0;
  logic        PixValid = 1'b0;
  logic        PixReady;
  logic        RdStart = 1'b0;
  logic        RdBusy, Underrun, PixOutValid;
  logic [23:0] PixOut, BufferIn0, BufferIn1;
  logic [6:0]  Addr0, Addr1;
  logic        WE0, WE1, RE0, RE1;
  logic [7:0]  Buf0OutR = '0, Buf0OutG = '0, Buf0OutB = '0;
  logic [7:0]  Buf1OutR = '0, Buf1OutG = '0, Buf1OutB = '0;
`ifdef LBC_UNDERRUN_CNT_EN
  logic [15:0] UnderrunCnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [23:0] q[$];
  logic [23:0] mem0 [128];
  logic [23:0] mem1 [128];

  line_buffer_ctrl #(.LINE_LEN(80), .ADDR_W(7), .DATA_W(24)) dut (
    .Clock(Clock), .Reset(Reset), .PixIn(PixIn), .PixValid(PixValid),
    .PixReady(PixReady), .RdStart(RdStart), .RdBusy(RdBusy),
    .Underrun(Underrun), .PixOut(PixOut), .PixOutValid(PixOutValid),
    .Addr0(Addr0), .Addr1(Addr1), .WE0(WE0), .WE1(WE1), .RE0(RE0), .RE1(RE1),
    .BufferIn0(BufferIn0), .BufferIn1(BufferIn1),
    .Buf0OutR(Buf0OutR), .Buf0OutG(Buf0OutG), .Buf0OutB(Buf0OutB),
    .Buf1OutR(Buf1OutR), .Buf1OutG(Buf1OutG), .Buf1OutB(Buf1OutB)
`ifdef LBC_UNDERRUN_CNT_EN
    , .UnderrunCnt(UnderrunCnt)
`endif
  );

  always #5 Clock = ~Clock;

  // Line buffer model: synchronous write, one-cycle registered read.
  always @(posedge Clock) begin
    if (WE0) mem0[Addr0] <= BufferIn0;
    if (RE0) {Buf0OutR, Buf0OutG, Buf0OutB} <= mem0[Addr0];
    if (WE1) mem1[Addr1] <= BufferIn1;
    if (RE1) {Buf1OutR, Buf1OutG, Buf1OutB} <= mem1[Addr1];
  end

  // Per-cycle monitor: bank exclusivity, idle-bank zeros, write data, scoreboard.
  always @(negedge Clock) begin
    logic [23:0] exp;
    #2;
    tests++;
    if ((WE0 && RE0) || (WE1 && RE1) || (WE0 && WE1) || (RE0 && RE1) ||
        (!WE0 && !RE0 && Addr0 != 0) || (!WE1 && !RE1 && Addr1 != 0) ||
        BufferIn0 !== PixIn || BufferIn1 !== PixIn) begin
      fails++;
      $display("FAIL bank_ctrl t=%0t WE=%b%b RE=%b%b A0=%0d A1=%0d required exclusive, idle zero, BufferIn=PixIn",
               $time, WE1, WE0, RE1, RE0, Addr0, Addr1);
    end
    if (PixOutValid === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL pixout_extra t=%0t got %h, required no output", $time, PixOut);
      end else begin
        exp = q.pop_front();
        if (PixOut !== exp) begin
          fails++;
          $display("FAIL pixout t=%0t got %h required %h", $time, PixOut, exp);
        end
      end
    end
    if (!Reset && PixValid && PixReady) q.push_back(PixIn);
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; PixValid = 1'b0; RdStart = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    q.delete();
    #1;
  endtask

  task automatic write_line(input logic [23:0] base);
    for (int k = 0; k < 80; k++) begin
      @(negedge Clock);
      PixValid = 1'b1; PixIn = base + 24'(k);
    end
    @(negedge Clock);
    PixValid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (PixReady !== 1'b1 || RdBusy !== 1'b0 || Underrun !== 1'b0 || PixOutValid !== 1'b0 ||
        {WE0, WE1, RE0, RE1} !== 4'b0 || Addr0 !== 7'd0 || Addr1 !== 7'd0) begin
      fails++;
      $display("FAIL reset_state rdy=%b busy=%b und=%b pov=%b we=%b%b re=%b%b required rdy=1 others 0",
               PixReady, RdBusy, Underrun, PixOutValid, WE1, WE0, RE1, RE0);
    end
  endtask

  task automatic test_fill_one();
    for (int k = 0; k < 80; k++) begin
      @(negedge Clock);
      PixValid = 1'b1; PixIn = 24'(k);
      #1;
      tests++;
      if (WE0 !== 1'b1 || Addr0 !== 7'(k) || WE1 !== 1'b0 || PixReady !== 1'b1) begin
        fails++;
        $display("FAIL fill_one k=%0d WE0=%b A0=%0d WE1=%b rdy=%b required WE0=1 A0=%0d WE1=0 rdy=1",
                 k, WE0, Addr0, WE1, PixReady, k);
      end
    end
    @(negedge Clock);
    PixValid = 1'b0;
    #1;
    tests++;
    if (PixReady !== 1'b1 || WE0 !== 1'b0 || WE1 !== 1'b0) begin
      fails++;
      $display("FAIL fill_one_end rdy=%b WE=%b%b required rdy=1 WE=00", PixReady, WE1, WE0);
    end
  endtask

  task automatic test_read_line();
    RdStart = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clock);
      RdStart = (i == 10);
      #1;
      tests++;
      if (RE0 !== 1'b1 || Addr0 !== 7'(i) || RE1 !== 1'b0 || RdBusy !== 1'b1 ||
          PixOutValid !== (i > 0) || Underrun !== 1'b0) begin
        fails++;
        $display("FAIL read_line i=%0d RE0=%b A0=%0d RE1=%b busy=%b pov=%b und=%b required RE0=1 A0=%0d busy=1 pov=%0d und=0",
                 i, RE0, Addr0, RE1, RdBusy, PixOutValid, Underrun, i, (i > 0));
      end
    end
    @(negedge Clock);
    RdStart = 1'b0;
    #1;
    tests++;
    if (RE0 !== 1'b0 || RdBusy !== 1'b0 || PixOutValid !== 1'b1) begin
      fails++;
      $display("FAIL read_line_tail RE0=%b busy=%b pov=%b required 0 0 1", RE0, RdBusy, PixOutValid);
    end
    @(negedge Clock);
    #1;
    tests++;
    if (PixOutValid !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL read_line_done pov=%b pending=%0d required pov=0 pending=0", PixOutValid, q.size());
    end
    // Bank 0 was freed and bank 1 is empty: a new request must underrun.
    RdStart = 1'b1;
    @(negedge Clock);
    RdStart = 1'b0;
    #1;
    tests++;
    if (Underrun !== 1'b1 || RdBusy !== 1'b0) begin
      fails++;
      $display("FAIL read_line_freed und=%b busy=%b required und=1 busy=0", Underrun, RdBusy);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    RdStart = 1'b1;
    @(negedge Clock);
    RdStart = 1'b0;
    #1;
    tests++;
    if (Underrun !== 1'b1 || RdBusy !== 1'b0 || RE0 !== 1'b0 || RE1 !== 1'b0) begin
      fails++;
      $display("FAIL underrun_pulse und=%b busy=%b RE=%b%b required und=1 busy=0 RE=00",
               Underrun, RdBusy, RE1, RE0);
    end
    @(negedge Clock);
    #1;
    tests++;
    if (Underrun !== 1'b0 || RdBusy !== 1'b0) begin
      fails++;
      $display("FAIL underrun_one_cycle und=%b busy=%b required 0 0", Underrun, RdBusy);
    end
`ifdef LBC_UNDERRUN_CNT_EN
    tests++;
    if (UnderrunCnt !== 16'd1) begin
      fails++;
      $display("FAIL underrun_cnt got %0d required 1", UnderrunCnt);
    end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 160; k++) begin
      @(negedge Clock);
      PixValid = 1'b1; PixIn = 24'h100000 + 24'(k);
      #1;
      tests++;
      if (PixReady !== 1'b1 || (k < 80 ? WE0 : WE1) !== 1'b1 ||
          (k < 80 ? Addr0 : Addr1) !== 7'(k % 80)) begin
        fails++;
        $display("FAIL stall_fill k=%0d rdy=%b WE=%b%b A0=%0d A1=%0d required rdy=1 addr %0d",
                 k, PixReady, WE1, WE0, Addr0, Addr1, k % 80);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      PixValid = 1'b1; PixIn = 24'h1000A0;
      #1;
      tests++;
      if (PixReady !== 1'b0 || WE0 !== 1'b0 || WE1 !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold c=%0d rdy=%b WE=%b%b required rdy=0 WE=00", c, PixReady, WE1, WE0);
      end
    end
    RdStart = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clock);
      RdStart = 1'b0;
      #1;
      tests++;
      if (PixReady !== 1'b0 || WE0 !== 1'b0 || RE0 !== 1'b1 || Addr0 !== 7'(i)) begin
        fails++;
        $display("FAIL stall_read i=%0d rdy=%b WE0=%b RE0=%b A0=%0d required rdy=0 WE0=0 RE0=1 A0=%0d",
                 i, PixReady, WE0, RE0, Addr0, i);
      end
    end
    @(negedge Clock);
    #1;
    tests++;
    if (PixReady !== 1'b1 || WE0 !== 1'b1 || Addr0 !== 7'd0) begin
      fails++;
      $display("FAIL stall_release rdy=%b WE0=%b A0=%0d required rdy=1 WE0=1 A0=0", PixReady, WE0, Addr0);
    end
    @(negedge Clock);
    PixValid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_line(24'h200000);
    RdStart = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clock);
      RdStart = 1'b0; PixValid = 1'b1; PixIn = 24'h300000 + 24'(i);
      #1;
      tests++;
      if (RE0 !== 1'b1 || Addr0 !== 7'(i) || WE1 !== 1'b1 || Addr1 !== 7'(i) || PixReady !== 1'b1) begin
        fails++;
        $display("FAIL b2b i=%0d RE0=%b A0=%0d WE1=%b A1=%0d rdy=%b required RE0=1 WE1=1 addrs %0d rdy=1",
                 i, RE0, Addr0, WE1, Addr1, PixReady, i);
      end
    end
    @(negedge Clock);
    PixValid = 1'b0; RdStart = 1'b1;
    #1;
    tests++;
    if (PixReady !== 1'b1 || RdBusy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_full rdy=%b busy=%b required rdy=1 busy=0", PixReady, RdBusy);
    end
    @(negedge Clock);
    RdStart = 1'b0;
    #1;
    tests++;
    if (RdBusy !== 1'b1 || RE1 !== 1'b1 || Addr1 !== 7'd0 || Underrun !== 1'b0) begin
      fails++;
      $display("FAIL b2b_read1 busy=%b RE1=%b A1=%0d und=%b required 1 1 0 0", RdBusy, RE1, Addr1, Underrun);
    end
    repeat (82) @(negedge Clock);
    #1;
    tests++;
    if (q.size() != 0 || RdBusy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain pending=%0d busy=%b required 0 0", q.size(), RdBusy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_line(24'h400000);
    RdStart = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge Clock);
      RdStart = 1'b0;
      Reset = (i == 40);
      #1;
      tests++;
      if (RE0 !== 1'b1 || Addr0 !== 7'(i)) begin
        fails++;
        $display("FAIL reset_mid_read i=%0d RE0=%b A0=%0d required RE0=1 A0=%0d", i, RE0, Addr0, i);
      end
    end
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    tests++;
    if (RE0 !== 1'b0 || RE1 !== 1'b0 || PixOutValid !== 1'b0 || PixReady !== 1'b1 || RdBusy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid RE=%b%b pov=%b rdy=%b busy=%b required RE=00 pov=0 rdy=1 busy=0",
               RE1, RE0, PixOutValid, PixReady, RdBusy);
    end
    q.delete();
    RdStart = 1'b1;
    @(negedge Clock);
    RdStart = 1'b0;
    #1;
    tests++;
    if (Underrun !== 1'b1 || RdBusy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_empty und=%b busy=%b required und=1 busy=0", Underrun, RdBusy);
    end
  endtask

  initial begin
    test_reset();
    test_fill_one();
    test_read_line();
    test_underrun();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
